// File: rtl/cpu_pkg.sv
// Shared opcodes, FSM state type and instruction field positions for the 16-bit core.
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_NOT  = 4'h6;
    localparam logic [3:0] OP_LDI  = 4'h7;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_JZ   = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int unsigned IR_OP_MSB   = 15;
    localparam int unsigned IR_OP_LSB   = 12;
    localparam int unsigned IR_RD_MSB   = 11;
    localparam int unsigned IR_RD_LSB   = 8;
    localparam int unsigned IR_RS1_MSB  = 7;
    localparam int unsigned IR_RS1_LSB  = 4;
    localparam int unsigned IR_RS2_MSB  = 3;
    localparam int unsigned IR_RS2_LSB  = 0;
    localparam int unsigned IR_IMM8_MSB = 7;
    localparam int unsigned IR_ADDR_MSB = 11;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StHalt
    } state_e;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_NOT);
    endfunction

endpackage

// File: rtl/reg_file.sv
// 16-entry register file: two combinational read ports, one synchronous write port.
module reg_file #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic [3:0]        raddr2_i,
    output logic [DATA_W-1:0] rdata2_o,
    input  logic              we_i,
    input  logic [3:0]        waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);

    logic [DATA_W-1:0] rf_q [16];
    logic [DATA_W-1:0] rf_d [16];

    always_comb begin
        rf_d = rf_q;
        if (we_i) begin
            rf_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            rf_q <= rf_d;
        end
    end

    assign rdata1_o = rf_q[raddr1_i];
    assign rdata2_o = rf_q[raddr2_i];

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer: owns PC, IR, zero flag and register file,
// drives the external ALU and the shared instruction/data memory.
module control_unit
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned DATA_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [15:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] alu_num1,
    output logic [DATA_W-1:0] alu_num2,
    output logic [3:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              halted,
    output logic [15:0]       pc
);

    state_e            state_q, state_d;
    logic [15:0]       pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              z_q, z_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;

    logic              rf_we;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rdata1, rf_rdata2;
    logic [3:0]        op;

    assign op = ir_q[IR_OP_MSB:IR_OP_LSB];
    assign pc = pc_q;

    reg_file #(
        .DATA_W (DATA_W)
    ) u_rf (
        .clk      (clk),
        .rst      (rst),
        .raddr1_i (ir_q[IR_RS1_MSB:IR_RS1_LSB]),
        .rdata1_o (rf_rdata1),
        .raddr2_i (ir_q[IR_RS2_MSB:IR_RS2_LSB]),
        .rdata2_o (rf_rdata2),
        .we_i     (rf_we),
        .waddr_i  (ir_q[IR_RD_MSB:IR_RD_LSB]),
        .wdata_i  (rf_wdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            z_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            z_q     <= z_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   state_d = StFetch;
            StFetch:  if (mem_ready) state_d = StDecode;
            StDecode: state_d = StExec;
            StExec: begin
                if (op == OP_LD || op == OP_ST) begin
                    state_d = StMem;
                end else if (op == OP_HALT) begin
                    state_d = StHalt;
                end else begin
                    state_d = StFetch;
                end
            end
            StMem:    if (mem_ready) state_d = StFetch;
            StHalt:   state_d = StHalt;
            default:  state_d = StIdle;
        endcase
    end

    // Datapath updates; every register holds unless its state explicitly loads it.
    always_comb begin
        pc_d     = pc_q;
        ir_d     = ir_q;
        z_d      = z_q;
        a_d      = a_q;
        b_d      = b_q;
        rf_we    = 1'b0;
        rf_wdata = alu_result;
        unique case (state_q)
            StFetch: begin
                if (mem_ready) begin
                    ir_d = mem_rdata;
                    pc_d = pc_q + 16'd1;
                end
            end
            StDecode: begin
                a_d = rf_rdata1;
                b_d = rf_rdata2;
            end
            StExec: begin
                if (is_alu_op(op)) begin
                    rf_we    = 1'b1;
                    rf_wdata = alu_result;
                    z_d      = alu_zero;
                end else if (op == OP_LDI) begin
                    rf_we    = 1'b1;
                    rf_wdata = DATA_W'(ir_q[IR_IMM8_MSB:0]);
                end else if (op == OP_JMP || (op == OP_JZ && z_q)) begin
                    pc_d = {4'h0, ir_q[IR_ADDR_MSB:0]};
                end
            end
            StMem: begin
                if (mem_ready && op == OP_LD) begin
                    rf_we    = 1'b1;
                    rf_wdata = mem_rdata;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        alu_num1   = '0;
        alu_num2   = '0;
        alu_opcode = OP_NOP;
        halted     = 1'b0;
        unique case (state_q)
            StFetch: begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
            end
            StExec: begin
                alu_num1 = a_q;
                alu_num2 = b_q;
                if (is_alu_op(op)) alu_opcode = op;
            end
            StMem: begin
                mem_req   = 1'b1;
                mem_we    = (op == OP_ST);
                mem_addr  = a_q;
                mem_wdata = b_q;
            end
            StHalt:  halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit with a behavioural ALU and a wait-state memory.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, mem_ready, halted;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, pc;
    logic [15:0] alu_num1, alu_num2, alu_result;
    logic [3:0]  alu_opcode;
    logic        alu_zero;

    logic        w_req, w_we, w_halted;
    logic [15:0] w_addr, w_wdata, w_rdata, w_pc, w_num1, w_num2;
    logic [3:0]  w_opcode;

    logic [15:0] mem [0:65535];
    logic        pl_we = 1'b0;
    logic [15:0] pl_addr = '0;
    logic [15:0] pl_data = '0;
    int unsigned wcnt = 0;
    int unsigned wait_n = 0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    control_unit u_dut (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .alu_num1   (alu_num1),
        .alu_num2   (alu_num2),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .halted     (halted),
        .pc         (pc)
    );

    // Second core starting at the top of the address space to exercise PC wrap.
    control_unit #(
        .RESET_PC (16'hFFFF)
    ) u_wrap (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (w_req),
        .mem_we     (w_we),
        .mem_addr   (w_addr),
        .mem_wdata  (w_wdata),
        .mem_rdata  (w_rdata),
        .mem_ready  (w_req),
        .alu_num1   (w_num1),
        .alu_num2   (w_num2),
        .alu_opcode (w_opcode),
        .alu_result (16'h0000),
        .alu_zero   (1'b0),
        .halted     (w_halted),
        .pc         (w_pc)
    );

    assign w_rdata = (w_addr == 16'hFFFF) ? 16'h0000 : 16'hF000;

    always_comb begin
        case (alu_opcode)
            4'h1:    alu_result = alu_num1 + alu_num2;
            4'h2:    alu_result = alu_num1 - alu_num2;
            4'h3:    alu_result = alu_num1 & alu_num2;
            4'h4:    alu_result = alu_num1 | alu_num2;
            4'h5:    alu_result = alu_num1 ^ alu_num2;
            4'h6:    alu_result = ~alu_num1;
            default: alu_result = alu_num1;
        endcase
    end
    assign alu_zero = (alu_result == 16'h0000);

    assign mem_ready = mem_req && (wcnt == wait_n);
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (pl_we) begin
            mem[pl_addr] <= pl_data;
        end else if (mem_req && mem_ready && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        if (mem_req && !mem_ready) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        pl_addr = a;
        pl_data = d;
        pl_we   = 1'b1;
        @(posedge clk);
        #1;
        pl_we   = 1'b0;
    endtask

    task automatic start_reset(input int unsigned ws);
        rst    = 1'b1;
        wait_n = ws;
        step(1);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_halt(input string tag);
        for (int i = 0; i < 400 && !halted; i++) step(1);
        check_eq(tag, 32'(halted), 32'd1);
    endtask

    initial begin
        // Reset state
        step(2);
        check_eq("rst_pc", 32'(pc), 32'h0000);
        check_eq("rst_req", 32'(mem_req), 32'd0);
        check_eq("rst_halted", 32'(halted), 32'd0);
        check_eq("rst_opcode", 32'(alu_opcode), 32'd0);
        check_eq("rst_z", 32'(u_dut.z_q), 32'd0);

        // LDI/LDI/SUB/JZ taken to HALT
        start_reset(0);
        poke(16'h0000, 16'h7105);
        poke(16'h0001, 16'h7205);
        poke(16'h0002, 16'h2312);
        poke(16'h0003, 16'hB010);
        poke(16'h0010, 16'hF000);
        release_reset();
        #1;
        check_eq("t1_idle_req", 32'(mem_req), 32'd0);
        step(1);
        check_eq("t1_fetch_req", 32'(mem_req), 32'd1);
        check_eq("t1_fetch_addr", 32'(mem_addr), 32'h0000);
        step(14);
        check_eq("t1_not_yet_halted", 32'(halted), 32'd0);
        step(1);
        check_eq("t1_halted", 32'(halted), 32'd1);
        check_eq("t1_pc", 32'(pc), 32'h0011);
        check_eq("t1_r3", 32'(u_dut.u_rf.rf_q[3]), 32'h0000);
        check_eq("t1_z", 32'(u_dut.z_q), 32'd1);
        step(2);
        check_eq("t1_halt_noreq", 32'(mem_req), 32'd0);

        // ADD then JZ not taken
        start_reset(0);
        poke(16'h0000, 16'h7103);
        poke(16'h0001, 16'h7204);
        poke(16'h0002, 16'h1312);
        poke(16'h0003, 16'hB020);
        poke(16'h0004, 16'hF000);
        poke(16'h0020, 16'hF000);
        release_reset();
        step(9);
        check_eq("t2_exec_opcode", 32'(alu_opcode), 32'h1);
        check_eq("t2_exec_num1", 32'(alu_num1), 32'h0003);
        check_eq("t2_exec_num2", 32'(alu_num2), 32'h0004);
        step(1);
        check_eq("t2_fetch_opcode", 32'(alu_opcode), 32'h0);
        wait_halt("t2_halt_seen");
        check_eq("t2_r3", 32'(u_dut.u_rf.rf_q[3]), 32'h0007);
        check_eq("t2_z", 32'(u_dut.z_q), 32'd0);
        check_eq("t2_pc", 32'(pc), 32'h0005);

        // ST/LD with two wait cycles per access
        start_reset(2);
        poke(16'h0000, 16'h7540);
        poke(16'h0001, 16'h7641);
        poke(16'h0002, 16'h8150);
        poke(16'h0003, 16'h8260);
        poke(16'h0004, 16'h9012);
        poke(16'h0005, 16'h8410);
        poke(16'h0006, 16'hF000);
        poke(16'h0040, 16'h0100);
        poke(16'h0041, 16'hBEEF);
        poke(16'h0100, 16'h0000);
        release_reset();
        for (int i = 0; i < 300 && !(mem_req && mem_we); i++) step(1);
        check_eq("t3_st_seen", 32'(mem_req && mem_we), 32'd1);
        check_eq("t3_st_addr0", 32'(mem_addr), 32'h0100);
        check_eq("t3_st_wdata", 32'(mem_wdata), 32'hBEEF);
        check_eq("t3_st_ready0", 32'(mem_ready), 32'd0);
        step(1);
        check_eq("t3_st_req1", 32'(mem_req && mem_we), 32'd1);
        check_eq("t3_st_addr1", 32'(mem_addr), 32'h0100);
        step(1);
        check_eq("t3_st_req2", 32'(mem_req && mem_we), 32'd1);
        check_eq("t3_st_addr2", 32'(mem_addr), 32'h0100);
        check_eq("t3_st_ready2", 32'(mem_ready), 32'd1);
        step(1);
        check_eq("t3_next_fetch_we", 32'(mem_we), 32'd0);
        check_eq("t3_next_fetch_addr", 32'(mem_addr), 32'h0005);
        for (int i = 0; i < 100 && !(mem_req && !mem_we && mem_addr == 16'h0100); i++) step(1);
        check_eq("t3_ld_seen", 32'(mem_req && !mem_we && mem_addr == 16'h0100), 32'd1);
        check_eq("t3_mem_written", 32'(mem[16'h0100]), 32'hBEEF);
        wait_halt("t3_halt_seen");
        check_eq("t3_r4", 32'(u_dut.u_rf.rf_q[4]), 32'hBEEF);
        check_eq("t3_r1", 32'(u_dut.u_rf.rf_q[1]), 32'h0100);

        // Reset during a fetch stall
        start_reset(5);
        poke(16'h0000, 16'h7105);
        poke(16'h0001, 16'h7207);
        poke(16'h0002, 16'hF000);
        release_reset();
        for (int i = 0; i < 100 && !(mem_req && pc == 16'h0001); i++) step(1);
        check_eq("t4_second_fetch", 32'(mem_req && pc == 16'h0001), 32'd1);
        step(2);
        check_eq("t4_stall_req", 32'(mem_req), 32'd1);
        check_eq("t4_stall_addr", 32'(mem_addr), 32'h0001);
        check_eq("t4_r1_before", 32'(u_dut.u_rf.rf_q[1]), 32'h0005);
        rst = 1'b1;
        #1;
        check_eq("t4_rst_req", 32'(mem_req), 32'd0);
        check_eq("t4_rst_pc", 32'(pc), 32'h0000);
        check_eq("t4_rst_r1", 32'(u_dut.u_rf.rf_q[1]), 32'h0000);
        step(1);
        release_reset();
        #1;
        check_eq("t4_idle_req", 32'(mem_req), 32'd0);
        step(1);
        check_eq("t4_refetch_req", 32'(mem_req), 32'd1);
        check_eq("t4_refetch_addr", 32'(mem_addr), 32'h0000);

        // PC wrap on the RESET_PC=FFFF instance
        start_reset(0);
        release_reset();
        #1;
        check_eq("t5_reset_pc", 32'(w_pc), 32'hFFFF);
        step(1);
        check_eq("t5_fetch_addr", 32'(w_addr), 32'hFFFF);
        check_eq("t5_fetch_req", 32'(w_req), 32'd1);
        step(1);
        check_eq("t5_pc_wrapped", 32'(w_pc), 32'h0000);
        step(2);
        check_eq("t5_next_fetch_addr", 32'(w_addr), 32'h0000);
        check_eq("t5_next_fetch_req", 32'(w_req), 32'd1);
        step(3);
        check_eq("t5_halted", 32'(w_halted), 32'd1);
        check_eq("t5_halt_pc", 32'(w_pc), 32'h0001);
        check_eq("t5_no_we", 32'(w_we), 32'd0);

        // NOT and undefined opcode 0xD
        start_reset(0);
        poke(16'h0000, 16'h6100);
        poke(16'h0001, 16'h6510);
        poke(16'h0002, 16'hD010);
        poke(16'h0003, 16'hF000);
        release_reset();
        step(6);
        check_eq("t6_z_after_not_r0", 32'(u_dut.z_q), 32'd0);
        step(3);
        check_eq("t6_z_after_not_r1", 32'(u_dut.z_q), 32'd1);
        step(2);
        check_eq("t6_undef_opcode", 32'(alu_opcode), 32'h0);
        wait_halt("t6_halt_seen");
        check_eq("t6_r1", 32'(u_dut.u_rf.rf_q[1]), 32'hFFFF);
        check_eq("t6_r5", 32'(u_dut.u_rf.rf_q[5]), 32'h0000);
        check_eq("t6_r0", 32'(u_dut.u_rf.rf_q[0]), 32'h0000);
        check_eq("t6_z", 32'(u_dut.z_q), 32'd1);
        check_eq("t6_pc", 32'(pc), 32'h0004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
